// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the matrix dot-product engine.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int prod_width(input int data_w);
    return 2 * data_w;
  endfunction

  // Lossless sum of n_lanes products needs clog2(n_lanes) extra bits.
  function automatic int tree_width(input int data_w, input int n_lanes);
    return 2 * data_w + clog2_int(n_lanes);
  endfunction

  localparam int DEF_PROD_W = prod_width(8);
  localparam int DEF_TREE_W = tree_width(8, 2);

endpackage

// File: rtl/mult_adder_tree.sv
// N_LANES unsigned multipliers feeding a lossless reduction, registered once (S2).
module mult_adder_tree
  import matrix_pkg::*;
#(
  parameter int N_LANES = 2,
  parameter int DATA_W  = 8,
  parameter int PROD_W  = prod_width(DATA_W),
  parameter int TREE_W  = tree_width(DATA_W, N_LANES)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic [N_LANES*DATA_W-1:0] a_i,
  input  logic [N_LANES*DATA_W-1:0] b_i,
  output logic                      valid_o,
  output logic [TREE_W-1:0]         sum_o
);

  logic [PROD_W-1:0] prod_c;
  logic [TREE_W-1:0] sum_c;
  logic              valid_q;
  logic [TREE_W-1:0] sum_q;

  // Operands are widened before multiplying so the product is never truncated.
  always_comb begin
    prod_c = '0;
    sum_c  = '0;
    for (int i = 0; i < N_LANES; i++) begin
      prod_c = {{DATA_W{1'b0}}, a_i[i*DATA_W +: DATA_W]} *
               {{DATA_W{1'b0}}, b_i[i*DATA_W +: DATA_W]};
      sum_c  = sum_c + TREE_W'(prod_c);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) sum_q <= sum_c;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/matrix_dot_engine.sv
// Dot-product/accumulate engine: S1 operand regs, S2 product tree, S3 accumulator.
// Define MATRIX_DOT_SAT_EN to clamp the accumulator on carry instead of wrapping.
module matrix_dot_engine
  import matrix_pkg::*;
#(
  parameter int N_LANES = 2,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20,
  parameter int LEN_W   = 8
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [LEN_W-1:0]          vec_len_i,
  input  logic                      in_valid_i,
  input  logic [N_LANES*DATA_W-1:0] in_a_i,
  input  logic [N_LANES*DATA_W-1:0] in_b_i,
  output logic                      busy_o,
  output logic                      out_valid_o,
  output logic [ACC_W-1:0]          out_result_o,
  output logic                      done_o,
  output logic                      overflow_o,
  output state_t                    dbg_state_o
);

  localparam int TREE_W = tree_width(DATA_W, N_LANES);
  localparam int SUM_W  = ACC_W + 1;

  state_t                    state_q, state_d;
  logic                      start_acc_c, beat_c;
  logic [LEN_W-1:0]          len_q, cnt_q;
  logic                      drain_q;
  logic                      s1_valid_q;
  logic [N_LANES*DATA_W-1:0] s1_a_q, s1_b_q;
  logic                      s2_valid;
  logic [TREE_W-1:0]         s2_sum;
  logic [SUM_W-1:0]          acc_sum_c;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic                      ovf_q;
  logic                      out_valid_q;
  logic [ACC_W-1:0]          out_result_q;

  always_comb begin
    state_d     = state_q;
    start_acc_c = 1'b0;
    beat_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          start_acc_c = 1'b1;
          state_d     = (vec_len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid_i) begin
          beat_c = 1'b1;
          if (cnt_q == len_q - LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_sum_c = {1'b0, acc_q} + SUM_W'(s2_sum);
`ifdef MATRIX_DOT_SAT_EN
    // Once clamped, any further non-zero add carries again, so it stays saturated.
    acc_d = acc_sum_c[ACC_W] ? {ACC_W{1'b1}} : acc_sum_c[ACC_W-1:0];
`else
    acc_d = acc_sum_c[ACC_W-1:0];
`endif
  end

  mult_adder_tree #(
    .N_LANES (N_LANES),
    .DATA_W  (DATA_W)
  ) u_tree (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .valid_i (s1_valid_q),
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .valid_o (s2_valid),
    .sum_o   (s2_sum)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= beat_c;
      if (beat_c) begin
        s1_a_q <= in_a_i;
        s1_b_q <= in_b_i;
      end
      if (start_acc_c) begin
        len_q <= vec_len_i;
        cnt_q <= '0;
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (beat_c) cnt_q <= cnt_q + LEN_W'(1);
        if (s2_valid) begin
          acc_q <= acc_d;
          ovf_q <= ovf_q | acc_sum_c[ACC_W];
        end
      end
      // Two DRAIN cycles cover S2 and S3 so DONE sees the final accumulator.
      drain_q     <= (state_q == DRAIN) ? ~drain_q : 1'b0;
      out_valid_q <= (state_q == DONE);
      if (state_q == DONE) out_result_q <= acc_q;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign out_valid_o  = out_valid_q;
  assign done_o       = out_valid_q;
  assign out_result_o = out_result_q;
  assign overflow_o   = ovf_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/matrix_dot_engine.md
Name: matrix_dot_engine

Overview:
- Parametrised dot-product and accumulate engine for the matrix-multiply datapath.
- Each beat multiplies N_LANES operand pairs, sums the products in a registered adder tree, and accumulates over a runtime vector length.
- Emits one result per row×column dot product with a done pulse.
- Generalises the fixed two-lane, fixed-width multiply path to configurable lanes and widths, with explicit start, length and valid control, and overflow detection.

Parameters:
N_LANES, 2, operand pairs multiplied per beat (power of two, ≥1)
DATA_W, 8, unsigned operand width
ACC_W, 20, accumulator/result width (≥ 2*DATA_W + clog2(N_LANES))
LEN_W, 8, width of vector-length input (beats per dot product)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a dot product; sampled only in IDLE
vec_len  in  LEN_W  number of beats; latched on accepted start
in_valid  in  1  in_a/in_b carry a valid beat
in_a  in  N_LANES*DATA_W  lane operands A, lane 0 in LSBs
in_b  in  N_LANES*DATA_W  lane operands B, lane 0 in LSBs
busy  out  1  high in any state other than IDLE
out_valid  out  1  one-cycle pulse, out_result valid
out_result  out  ACC_W  final accumulated dot product, held until next out_valid
done  out  1  one-cycle pulse, coincident with out_valid
overflow  out  1  accumulator exceeded ACC_W during the current/last operation; held until next accepted start

Behaviour:
- Reset: FSM=IDLE; all pipeline valids, counters and accumulator cleared; busy, out_valid, done and overflow = 0; out_result = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN: start=1 and vec_len≠0. Latch vec_len, clear the beat counter, accumulator and overflow.
- IDLE→DONE: start=1 and vec_len=0. Produces out_result=0, overflow=0.
- RUN: each cycle with in_valid=1 is a beat; the counter increments. When the beat with counter = vec_len−1 is accepted, go to DRAIN.
- RUN with in_valid gaps: the FSM waits indefinitely; there is no timeout.
- DRAIN: stays exactly 2 cycles while the pipeline empties, then goes to DONE.
- DONE: one cycle. out_valid=done=1, out_result=accumulator. Next state IDLE.
- start outside IDLE: ignored.
- in_valid outside RUN: ignored; no beat is counted.
- Pipeline:
  - S1 registers operands and a valid bit.
  - S2 registers the sum of N_LANES products (width 2*DATA_W+clog2(N_LANES)).
  - S3 adds the S2 sum into the accumulator when S2 is valid.
- Latency: out_valid rises at the 3rd rising edge after the edge that sampled the final beat.
- Arithmetic: unsigned. Products are 2*DATA_W bits; the tree is lossless.
- Accumulator wraps modulo 2^ACC_W. overflow sets sticky on any carry out of ACC_W.
- Reset mid-operation: immediate return to the reset state; any partial result is discarded and no done pulse is issued.

Optional Feature:
MATRIX_DOT_SAT_EN
- Defined: on a carry out, the accumulator clamps to 2^ACC_W−1 and remains saturated for the rest of the operation. overflow is still set.
- Undefined: wrap-around as above.

Decomposition:
- Package matrix_pkg: state enum (IDLE, RUN, DRAIN, DONE); localparams for product width (2*DATA_W) and tree width; a function for clog2-based tree sizing.
- Sub-module mult_adder_tree: N_LANES multipliers plus the registered reduction tree (S2), parametrised by N_LANES and DATA_W.

Test Plan:
1. len=1, a={2,3}, b={5,4} (lane1,lane0) → out_result=22, out_valid+done exactly 3 edges after the beat, overflow=0.
2. len=4, all operands 255, in_valid every cycle → out_result=520200, overflow=0. Repeat with in_valid gaps (beats on alternate cycles) → same result; busy stays high throughout.
3. len=10, all operands 255 → out_result=251924, overflow=1. With MATRIX_DOT_SAT_EN: out_result=1048575, overflow=1.
4. start with vec_len=0 → done/out_valid one cycle later (at the edge after DONE is entered), out_result=0. A second start while busy is ignored and the beat count is unaffected.
5. Assert reset after 2 of 4 beats → busy=0, no done pulse, out_result=0. A new len=1 run with a={1,1}, b={1,1} → out_result=2.
6. in_valid pulses while IDLE, then start len=2 with beats a={1,0}, b={7,0} twice → out_result=14; the IDLE beats are not counted.
